demux8way16_buf: RTL and testbench

- Registered 8-way, 16-bit distributor: one 16-bit input stream is steered to one of 8 output channels, or broadcast to all 8.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Sits downstream of the mux8way16 datapath. It is the fan-out side that returns a shared 16-bit bus to per-destination consumers.
- Also keeps a wrap-around count of accepted transfers for debug.

---
 rtl/demux8way16_buf.sv | 88 ++++++++
 tb/tb_demux8way16_buf.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/demux8way16_buf.sv
// Registered 1-to-WAYS distributor: steers or broadcasts one input word into
// per-channel one-entry holding registers with valid/ready handshakes.
`timescale 1ns/1ps
module demux8way16_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WAYS  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [$clog2(WAYS)-1:0] in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WAYS*WIDTH-1:0]   out_data,
    output logic [WAYS-1:0]         out_valid,
    input  logic [WAYS-1:0]         out_ready,
    output logic [15:0]             accept_cnt
);

    localparam int unsigned SelW = $clog2(WAYS);

    typedef enum logic {StEmpty, StFull} ch_state_e;

    ch_state_e        state_q [WAYS];
    ch_state_e        state_d [WAYS];
    logic [WIDTH-1:0] data_q  [WAYS];
    logic [WIDTH-1:0] data_d  [WAYS];
    logic [15:0]      cnt_q, cnt_d;

    logic [WAYS-1:0] free;
    logic [WAYS-1:0] wr;
    logic            accept;

    // A channel is free when empty or being drained this cycle.
    always_comb begin
        free = '0;
        for (int k = 0; k < WAYS; k++) begin
            free[k] = (state_q[k] == StEmpty) || out_ready[k];
        end
    end

    assign in_ready = in_bcast ? (&free) : free[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr    = '0;
        cnt_d = accept ? cnt_q + 16'd1 : cnt_q;
        for (int k = 0; k < WAYS; k++) begin
            wr[k]      = accept & (in_bcast | (in_sel == SelW'(k)));
            state_d[k] = state_q[k];
            data_d[k]  = wr[k] ? in_data : data_q[k];
            unique case (state_q[k])
                StEmpty: if (wr[k]) state_d[k] = StFull;
                StFull:  if (!wr[k] && out_ready[k]) state_d[k] = StEmpty;
                default: state_d[k] = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int k = 0; k < WAYS; k++) begin
                state_q[k] <= StEmpty;
                data_q[k]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < WAYS; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < WAYS; k++) begin
            out_valid[k]                = (state_q[k] == StFull);
            out_data[k*WIDTH +: WIDTH]  = data_q[k];
        end
    end

    assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux8way16_buf.sv
// Directed self-checking bench for demux8way16_buf.
`timescale 1ns/1ps
module tb_demux8way16_buf;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_bcast;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [15:0]  accept_cnt;

    int checks = 0;
    int errors = 0;

    demux8way16_buf dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int k);
        return out_data[k*16 +: 16];
    endfunction

    initial begin
        reset     = 1'b1;
        in_data   = 16'($urandom);
        in_sel    = 3'($urandom);
        in_bcast  = 1'($urandom);
        in_valid  = 1'b1;
        out_ready = 8'($urandom);
        tick();
        in_data   = 16'($urandom);
        in_bcast  = 1'($urandom);
        out_ready = 8'($urandom);
        tick();
        check("rst_valid", 128'(out_valid), 128'h0);
        check("rst_data", out_data, 128'h0);
        check("rst_cnt", 128'(accept_cnt), 128'h0);
        in_bcast  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            check("rst_in_ready", 128'(in_ready), 128'h1);
        end
        tick();
        reset = 1'b0;

        // Unicast fill with backpressure
        in_valid = 1'b1; in_sel = 3'd3; in_data = 16'h1234;
        #1 check("uni_ready3", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        check("uni_valid08", 128'(out_valid), 128'h08);
        check("uni_lane3", 128'(lane(3)), 128'h1234);
        check("uni_cnt1", 128'(accept_cnt), 128'd1);
        in_valid = 1'b1; in_data = 16'hBEEF;
        #1 check("uni_stall_ready", 128'(in_ready), 128'h0);
        tick();
        check("uni_stall_valid", 128'(out_valid), 128'h08);
        check("uni_stall_lane3", 128'(lane(3)), 128'h1234);
        check("uni_stall_cnt", 128'(accept_cnt), 128'd1);
        in_sel = 3'd5; in_data = 16'h5555;
        #1 check("uni_ready5", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        check("uni_valid28", 128'(out_valid), 128'h28);
        check("uni_lane5", 128'(lane(5)), 128'h5555);
        check("uni_lane3_kept", 128'(lane(3)), 128'h1234);
        check("uni_cnt2", 128'(accept_cnt), 128'd2);
        out_ready = 8'hFF;
        tick();
        check("drain_valid", 128'(out_valid), 128'h00);
        check("drain_hold3", 128'(lane(3)), 128'h1234);

        // Back-to-back streaming on channel 0
        in_sel = 3'd0; in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 16'(i);
            #1 check("stream_ready", 128'(in_ready), 128'h1);
            tick();
            check("stream_lane0", 128'(lane(0)), 128'(i));
            check("stream_valid", 128'(out_valid), 128'h01);
        end
        in_valid = 1'b0;
        tick();
        check("stream_cnt", 128'(accept_cnt), 128'd12);
        check("stream_drained", 128'(out_valid), 128'h00);

        // Broadcast gated by a full channel 6
        out_ready = 8'h00; in_sel = 3'd6; in_data = 16'h0606; in_valid = 1'b1;
        tick();
        check("bc_pre_valid", 128'(out_valid), 128'h40);
        in_bcast = 1'b1; in_data = 16'hA5A5;
        #1 check("bc_blocked", 128'(in_ready), 128'h0);
        tick();
        check("bc_blocked_valid", 128'(out_valid), 128'h40);
        check("bc_blocked_cnt", 128'(accept_cnt), 128'd13);
        out_ready = 8'h40;
        #1 check("bc_ready", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
        check("bc_valid", 128'(out_valid), 128'hFF);
        check("bc_data", out_data, {8{16'hA5A5}});
        check("bc_cnt", 128'(accept_cnt), 128'd14);

        // Drain and write the same channel in one cycle
        out_ready = 8'h04; in_sel = 3'd2; in_data = 16'h0001; in_valid = 1'b1;
        tick();
        check("dw1_lane2", 128'(lane(2)), 128'h0001);
        check("dw1_valid", 128'(out_valid), 128'hFF);
        in_data = 16'h0002;
        #1 check("dw_ready", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        check("dw_valid", 128'(out_valid), 128'hFF);
        check("dw_lane2", 128'(lane(2)), 128'h0002);
        check("dw_lane1", 128'(lane(1)), 128'hA5A5);
        check("dw_cnt", 128'(accept_cnt), 128'd16);

        // Counter wrap: 16 accepts so far, 65519 more reach 0xFFFF
        out_ready = 8'hFF; in_sel = 3'd0; in_valid = 1'b1;
        repeat (65519) begin
            in_data = 16'($urandom);
            tick();
        end
        check("cnt_max", 128'(accept_cnt), 128'hFFFF);
        tick();
        check("cnt_wrap", 128'(accept_cnt), 128'h0000);

        // Mid-operation reset with all channels full
        in_bcast = 1'b1; in_data = 16'hCAFE;
        tick();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
        check("pre_rst_valid", 128'(out_valid), 128'hFF);
        check("pre_rst_data", out_data, {8{16'hCAFE}});
        check("pre_rst_cnt", 128'(accept_cnt), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 128'(out_valid), 128'h00);
        check("mid_rst_data", out_data, 128'h0);
        check("mid_rst_cnt", 128'(accept_cnt), 128'h0);
        tick();
        check("post_rst_valid", 128'(out_valid), 128'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
